txpause_sched: RTL and testbench

//  TX-side 802.3x flow-control scheduler between the user AXIS TX stream and the MAC TX datapath.

---
 rtl/txpause_sched_if.sv | 19 +
 rtl/txpause_sched.sv | 187 ++++++++++++++++++
 tb/tb_txpause_sched.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/txpause_sched_if.sv
// AXI-Stream beat bundle (64-bit data, byte keep) shared by the user TX
// stream and the MAC TX stream of txpause_sched.
interface txpause_sched_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (
        output tdata, tkeep, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/txpause_sched.sv
// 802.3x TX scheduler: frame-boundary arbitration between user frames and locally generated PAUSE frames.
// Optional XON (quanta 0) on xoff_req falling edge when TXPAUSE_XON_EN is defined.
module txpause_sched #(
    parameter logic [47:0] SRC_MAC = 48'h02_00_00_00_00_01
) (
    input  logic                   clk,
    input  logic                   rst,
    txpause_sched_if.slave         s_axis,
    txpause_sched_if.master        m_axis,
    input  logic                   rx_pause_active,
    input  logic                   xoff_req,
    input  logic                   cfg_tx_pause_enable,
    input  logic [15:0]            cfg_pause_quanta,
    input  logic [15:0]            cfg_refresh_interval,
    output logic                   tx_paused,
    output logic [15:0]            pause_frames_sent
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_USER  = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic [15:0] quanta_q, quanta_d;
    logic        frame_xoff_q, frame_xoff_d;
    logic        xoff_prev_q;
    logic        xoff_pend_q, xoff_pend_d;
    logic        xon_pend;
    logic [15:0] timer_q, timer_d;
    logic        tx_paused_q, tx_paused_d;
    logic [15:0] cnt_q, cnt_d;

    logic xoff_rise;
    logic refresh_fire;
    logic start_pause;
    logic user_end;
    logic last_acc;

    assign xoff_rise    = xoff_req && !xoff_prev_q;
    // Fires on the cycle the timer steps from 1 to 0, not every cycle it sits at 0.
    assign refresh_fire = xoff_req && (timer_q == 16'd1);
    assign start_pause  = (state_q == S_IDLE) && cfg_tx_pause_enable && (xoff_pend_q || xon_pend);
    assign user_end     = (state_q == S_USER) && s_axis.tvalid && m_axis.tready && s_axis.tlast;
    assign last_acc     = (state_q == S_PAUSE) && m_axis.tready && (beat_q == 3'd7);

`ifdef TXPAUSE_XON_EN
    logic xon_pend_q, xon_pend_d;
    logic xoff_fall;

    assign xoff_fall = !xoff_req && xoff_prev_q;
    assign xon_pend  = xon_pend_q;

    always_comb begin
        xon_pend_d = xon_pend_q;
        if (start_pause || xoff_rise) xon_pend_d = 1'b0;
        if (xoff_fall)                xon_pend_d = 1'b1;
        if (!cfg_tx_pause_enable)     xon_pend_d = 1'b0;
    end
`else
    assign xon_pend = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        quanta_d     = quanta_q;
        frame_xoff_d = frame_xoff_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_pause) begin
                    state_d      = S_PAUSE;
                    beat_d       = 3'd0;
                    quanta_d     = xoff_req ? cfg_pause_quanta : '0;
                    frame_xoff_d = xoff_req;
                end else if (s_axis.tvalid && !rx_pause_active) begin
                    state_d = S_USER;
                end
            end
            S_USER: begin
                if (user_end) state_d = S_IDLE;
            end
            S_PAUSE: begin
                if (m_axis.tready) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = S_IDLE;
                        cnt_d   = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        xoff_pend_d = xoff_pend_q;
        if (start_pause)              xoff_pend_d = 1'b0;
        if (xoff_rise || refresh_fire) xoff_pend_d = 1'b1;
        if (!cfg_tx_pause_enable)     xoff_pend_d = 1'b0;
    end

    always_comb begin
        timer_d = timer_q;
        if (!xoff_req) begin
            timer_d = '0;
        end else if (last_acc && frame_xoff_q && (cfg_refresh_interval != 16'd0)) begin
            timer_d = cfg_refresh_interval;
        end else if (timer_q != 16'd0) begin
            timer_d = timer_q - 16'd1;
        end
    end

    assign tx_paused_d = rx_pause_active && (state_q != S_USER);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            quanta_q     <= '0;
            frame_xoff_q <= 1'b0;
            xoff_prev_q  <= 1'b0;
            xoff_pend_q  <= 1'b0;
            timer_q      <= '0;
            tx_paused_q  <= 1'b0;
            cnt_q        <= '0;
`ifdef TXPAUSE_XON_EN
            xon_pend_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            quanta_q     <= quanta_d;
            frame_xoff_q <= frame_xoff_d;
            xoff_prev_q  <= xoff_req;
            xoff_pend_q  <= xoff_pend_d;
            timer_q      <= timer_d;
            tx_paused_q  <= tx_paused_d;
            cnt_q        <= cnt_d;
`ifdef TXPAUSE_XON_EN
            xon_pend_q   <= xon_pend_d;
`endif
        end
    end

    // Byte n of each beat sits on tdata[8n+7:8n]; frame is 60 bytes, FCS added by the MAC.
    always_comb begin
        s_axis.tready = 1'b0;
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = '0;
        m_axis.tkeep  = '0;
        m_axis.tlast  = 1'b0;
        case (state_q)
            S_USER: begin
                m_axis.tvalid = s_axis.tvalid;
                m_axis.tdata  = s_axis.tdata;
                m_axis.tkeep  = s_axis.tkeep;
                m_axis.tlast  = s_axis.tlast;
                s_axis.tready = m_axis.tready;
            end
            S_PAUSE: begin
                m_axis.tvalid = 1'b1;
                m_axis.tkeep  = 8'hFF;
                case (beat_q)
                    3'd0: m_axis.tdata = {SRC_MAC[39:32], SRC_MAC[47:40],
                                          8'h01, 8'h00, 8'h00, 8'hC2, 8'h80, 8'h01};
                    3'd1: m_axis.tdata = {8'h01, 8'h00, 8'h08, 8'h88,
                                          SRC_MAC[7:0], SRC_MAC[15:8], SRC_MAC[23:16], SRC_MAC[31:24]};
                    3'd2: m_axis.tdata = {48'h0, quanta_q[7:0], quanta_q[15:8]};
                    3'd7: begin
                        m_axis.tkeep = 8'h0F;
                        m_axis.tlast = 1'b1;
                    end
                    default: m_axis.tdata = '0;
                endcase
            end
            default: ;
        endcase
    end

    assign tx_paused         = tx_paused_q;
    assign pause_frames_sent = cnt_q;

endmodule

// File: tb/tb_txpause_sched.sv
// Randomised self-checking bench for txpause_sched: user frames scoreboarded,
// PAUSE frames compared against a 60-byte frame image built from the frame format.
module tb_txpause_sched;

    localparam logic [47:0] TB_MAC = 48'h02_AB_CD_EF_12_34;
`ifdef TXPAUSE_XON_EN
    localparam int XON_FRAMES = 1;
`else
    localparam int XON_FRAMES = 0;
`endif

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_pause_active, xoff_req, cfg_tx_pause_enable;
    logic [15:0] cfg_pause_quanta, cfg_refresh_interval;
    logic        tx_paused;
    logic [15:0] pause_frames_sent;

    txpause_sched_if s_if ();
    txpause_sched_if m_if ();

    txpause_sched #(.SRC_MAC(TB_MAC)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_axis               (s_if),
        .m_axis               (m_if),
        .rx_pause_active      (rx_pause_active),
        .xoff_req             (xoff_req),
        .cfg_tx_pause_enable  (cfg_tx_pause_enable),
        .cfg_pause_quanta     (cfg_pause_quanta),
        .cfg_refresh_interval (cfg_refresh_interval),
        .tx_paused            (tx_paused),
        .pause_frames_sent    (pause_frames_sent)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference PAUSE frame: byte image, then cut into 8-byte beats.
    function automatic beat_t pause_beat(input int b, input logic [15:0] q);
        logic [7:0] fr [64];
        beat_t r;
        logic [47:0] da;
        da = 48'h01_80_C2_00_00_01;
        for (int i = 0; i < 64; i++) fr[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            fr[i]     = da[47 - 8*i -: 8];
            fr[6 + i] = TB_MAC[47 - 8*i -: 8];
        end
        fr[12] = 8'h88; fr[13] = 8'h08; fr[14] = 8'h00; fr[15] = 8'h01;
        fr[16] = q[15:8]; fr[17] = q[7:0];
        for (int i = 0; i < 8; i++) r.data[8*i +: 8] = fr[8*b + i];
        r.keep = (b == 7) ? 8'h0F : 8'hFF;
        r.last = (b == 7);
        return r;
    endfunction

    beat_t src_q[$];
    beat_t exp_q[$];
    int    frame_log[$];     // 1 = user frame, 2 = PAUSE frame, in output order
    int    xoff_starts[$];

    int cyc = 0;
    int src_pct = 80;
    int rdy_pct = 100;

    bit          in_frame = 0, frame_is_pause = 0;
    int          pb = 0;
    logic [15:0] q_exp = '0;
    int          n_pause_done = 0, n_user_done = 0, n_user_beats = 0;
    bit          last_xoff = 0, last_rxp = 0, last_in_user = 0, last_rst = 1;
    logic [15:0] last_cfg_q = '0;
    bit          s_acc = 0;
    int          last_user_end_cyc = 0, pause_start_cyc = 0, pause_gap = 0;
    logic [15:0] b2_word = '0;
    logic [7:0]  b7_keep = '0;

    task automatic monitor();
        bit    in_user_now;
        beat_t e;
        if (rst) begin
            if (last_rst) begin
                check("rst_m_tvalid", m_if.tvalid, 0);
                check("rst_s_tready", s_if.tready, 0);
                check("rst_tx_paused", tx_paused, 0);
                check("rst_count", pause_frames_sent, 0);
            end
            in_frame = 0; n_pause_done = 0; last_in_user = 0;
            last_rst = 1; last_xoff = xoff_req; last_rxp = rx_pause_active;
            last_cfg_q = cfg_pause_quanta; s_acc = 0;
            return;
        end
        check("tx_paused", tx_paused, last_rst ? 1'b0 : (last_rxp && !last_in_user));
        check("pause_count", pause_frames_sent, 16'(n_pause_done));
        if (s_if.tready) begin
            check("pass_tready", m_if.tready, 1);
            check("pass_beat", {m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast},
                               {s_if.tvalid, s_if.tdata, s_if.tkeep, s_if.tlast});
        end
        if (!in_frame && m_if.tvalid) begin
            in_frame = 1; pb = 0;
            frame_is_pause = (m_if.tdata[47:0] == 48'h01_00_00_C2_80_01);
            if (frame_is_pause) begin
                q_exp = last_xoff ? last_cfg_q : 16'h0000;
                pause_start_cyc = cyc;
                pause_gap = cyc - last_user_end_cyc;
                if (last_xoff) xoff_starts.push_back(cyc);
                frame_log.push_back(2);
            end else begin
                check("user_start_rxp", last_rxp, 0);
                frame_log.push_back(1);
            end
        end
        in_user_now = in_frame && !frame_is_pause;
        if (!in_user_now) check("s_tready_outside", s_if.tready, 0);
        if (in_frame && frame_is_pause) begin
            check("pause_tvalid", m_if.tvalid, 1);
            check($sformatf("pause_b%0d", pb), {m_if.tdata, m_if.tkeep, m_if.tlast}, pause_beat(pb, q_exp));
            if (m_if.tready) begin
                if (pb == 2) b2_word = m_if.tdata[15:0];
                if (pb == 7) b7_keep = m_if.tkeep;
                pb++;
                if (pb == 8) begin
                    in_frame = 0;
                    n_pause_done++;
                end
            end
        end else if (in_frame && m_if.tvalid && m_if.tready) begin
            n_user_beats++;
            if (exp_q.size() == 0) begin
                check("user_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("user_beat", {m_if.tdata, m_if.tkeep, m_if.tlast}, e);
            end
            if (m_if.tlast) begin
                in_frame = 0;
                n_user_done++;
                last_user_end_cyc = cyc;
            end
        end
        last_in_user = in_user_now;
        last_xoff    = xoff_req;
        last_rxp     = rx_pause_active;
        last_cfg_q   = cfg_pause_quanta;
        last_rst     = 0;
        s_acc        = s_if.tvalid && s_if.tready;
    endtask

    task automatic drive();
        beat_t b;
        if (s_acc) s_if.tvalid = 1'b0;
        if (!s_if.tvalid && src_q.size() > 0 && $urandom_range(0, 99) < src_pct) begin
            b = src_q.pop_front();
            s_if.tdata  = b.data;
            s_if.tkeep  = b.keep;
            s_if.tlast  = b.last;
            s_if.tvalid = 1'b1;
        end
        m_if.tready = ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic add_frame(input int nbeats);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data = {$urandom, $urandom};
            if (i == 0) b.data[7:0] = 8'h00;
            b.last = (i == nbeats - 1);
            b.keep = b.last ? 8'($urandom_range(1, 255)) : 8'hFF;
            src_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !in_frame) break;
            tick();
        end
        check(tag, exp_q.size(), 0);
        ticks(20);
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_user_beats >= target) break;
            tick();
        end
        check(tag, n_user_beats >= target, 1);
    endtask

    initial begin
        int base_p, base_u, log0, xs0, rise_cyc;
        rst = 1; rx_pause_active = 0; xoff_req = 0; cfg_tx_pause_enable = 1;
        cfg_pause_quanta = 16'h0000; cfg_refresh_interval = 16'd0;
        s_if.tvalid = 0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 0;
        m_if.tready = 1;
        ticks(3);
        rst = 0;
        ticks(3);

        // T1: back-to-back user frames, full throughput
        src_pct = 100; rdy_pct = 100; log0 = frame_log.size();
        add_frame(3); add_frame(1); add_frame(5);
        drain("t1_drain", 200);
        check("t1_frames", n_user_done, 3);
        check("t1_no_pause", n_pause_done, 0);
        check("t1_log", frame_log.size() - log0, 3);

        // T2: XOFF on rising edge with quanta 0x1234
        cfg_pause_quanta = 16'h1234; base_p = n_pause_done;
        xoff_req = 1; rise_cyc = cyc;
        ticks(30);
        check("t2_count", n_pause_done - base_p, 1);
        check("t2_latency", pause_start_cyc - rise_cyc, 2);
        check("t2_b2", b2_word, 16'h3412);
        check("t2_b7keep", b7_keep, 8'h0F);
        xoff_req = 0;
        ticks(30);
        check("t2_after_fall", n_pause_done - base_p, 1 + XON_FRAMES);

        // T3: XOFF raised mid user frame, served at the next boundary
        src_pct = 100; cfg_pause_quanta = 16'hBEEF; base_p = n_pause_done; log0 = frame_log.size();
        add_frame(8); add_frame(3);
        wait_beats("t3_wait", n_user_beats + 2, 50);
        xoff_req = 1;
        drain("t3_drain", 200);
        check("t3_count", n_pause_done - base_p, 1);
        check("t3_gap", pause_gap, 2);
        check("t3_nlog", frame_log.size() - log0, 3);
        if (frame_log.size() - log0 == 3) begin
            check("t3_order0", frame_log[log0], 1);
            check("t3_order1", frame_log[log0 + 1], 2);
            check("t3_order2", frame_log[log0 + 2], 1);
        end
        xoff_req = 0;
        ticks(30);

        // T4: partner pause holds off the next frame but not our PAUSE
        base_u = n_user_done; base_p = n_pause_done;
        add_frame(6); add_frame(6);
        wait_beats("t4_wait", n_user_beats + 2, 50);
        rx_pause_active = 1;
        ticks(40);
        check("t4_first_done", n_user_done - base_u, 1);
        check("t4_second_held", exp_q.size(), 6);
        check("t4_tx_paused", tx_paused, 1);
        xoff_req = 1;
        ticks(30);
        check("t4_pause_sent", n_pause_done - base_p, 1);
        xoff_req = 0;
        ticks(30);
        rx_pause_active = 0;
        drain("t4_drain", 200);
        check("t4_second_done", n_user_done - base_u, 2);
        check("t4_xon", n_pause_done - base_p, 1 + XON_FRAMES);

        // Generation disabled: edges ignored entirely
        cfg_tx_pause_enable = 0; base_p = n_pause_done;
        for (int i = 0; i < 4; i++) begin
            xoff_req = ~xoff_req;
            ticks(20);
        end
        check("dis_count", n_pause_done - base_p, 0);
        cfg_tx_pause_enable = 1;
        ticks(5);

        // T5: periodic XOFF refresh while xoff held
        cfg_refresh_interval = 16'd100; cfg_pause_quanta = 16'h00FF;
        base_p = n_pause_done; xs0 = xoff_starts.size();
        xoff_req = 1;
        ticks(460);
        check("t5_refreshes", (xoff_starts.size() - xs0) >= 4, 1);
        for (int i = xs0 + 1; i < xoff_starts.size(); i++) begin
            check("t5_spacing_min", (xoff_starts[i] - xoff_starts[i-1]) >= 100, 1);
            check("t5_spacing_max", (xoff_starts[i] - xoff_starts[i-1]) <= 112, 1);
        end
        base_p = n_pause_done;
        xoff_req = 0;
        ticks(300);
        check("t5_stop", n_pause_done - base_p, XON_FRAMES);

        // T6: random traffic, backpressure, xoff and partner pause
        cfg_refresh_interval = 16'd37; cfg_pause_quanta = 16'($urandom);
        src_pct = 70; rdy_pct = 60;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) xoff_req = ~xoff_req;
            if ($urandom_range(0, 149) == 0) rx_pause_active = ~rx_pause_active;
            if (src_q.size() < 4 && $urandom_range(0, 19) == 0) add_frame($urandom_range(1, 8));
            tick();
        end
        rx_pause_active = 0; xoff_req = 0; rdy_pct = 100;
        drain("t6_drain", 2000);

        // xoff_req high through reset yields an XOFF right after release
        rst = 1; xoff_req = 1;
        ticks(3);
        rst = 0;
        ticks(20);
        check("rst_xoff_count", pause_frames_sent, 16'd1);
        check("rst_xoff_model", n_pause_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
